// File: rtl/dmem_ctrl.sv
// Data-memory controller: adapts 64-bit CPU loads/stores onto a 32-bit single-port RAM
// with a one-cycle read latency. Multi-beat accesses stall the CPU memory stage.
module dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  input  logic [1:0]  memwrite,
  input  logic        memread,
  input  logic        dword,
  output logic [63:0] readdata,
  output logic        stall,
  output logic        align_err,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  cap_addr;
  logic [31:0] cap_hi;
  logic        cap_dword;
  logic        capture;
  logic        ld_lo;
  logic        ld_hi;
  logic        is_store;
  logic        is_load;
  logic        req_dw;
  logic        req_byte;
  logic        misaligned;
  logic [9:0]  hi_addr;
  logic        unused_bits;

  assign unused_bits = ^{dataadr[63:12], writedata[63:32] & 32'h0};
  assign fsm_state   = state;

  // Stores take priority over loads when both are requested.
  assign is_store   = (memwrite != 2'b00);
  assign is_load    = !is_store && memread;
  assign req_dw     = is_store ? (memwrite == 2'b11) : dword;
  assign req_byte   = (memwrite == 2'b10);
  assign misaligned = (is_store || is_load) &&
                      (req_dw ? (dataadr[2:0] != 3'b000)
                              : (!req_byte && (dataadr[1:0] != 2'b00)));
  assign hi_addr    = cap_addr + 10'd1;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    align_err  = 1'b0;
    ram_addr   = cap_addr;
    ram_wdata  = 32'h0;
    ram_we     = 1'b0;
    ram_be     = 4'b0000;
    capture    = 1'b0;
    ld_lo      = 1'b0;
    ld_hi      = 1'b0;
    case (state)
      IDLE: begin
        ram_addr = dataadr[11:2];
        if (misaligned) begin
          align_err = 1'b1;
        end else if (is_store) begin
          ram_we = 1'b1;
          case (memwrite)
            2'b01: begin
              ram_be    = 4'b1111;
              ram_wdata = writedata[31:0];
            end
            2'b10: begin
              ram_be    = 4'b0001 << dataadr[1:0];
              ram_wdata = {4{writedata[7:0]}};
            end
            2'b11: begin
              ram_be     = 4'b1111;
              ram_wdata  = writedata[31:0];
              stall      = 1'b1;
              capture    = 1'b1;
              state_next = WR_HI;
            end
            default: ;
          endcase
        end else if (is_load) begin
          stall      = 1'b1;
          capture    = 1'b1;
          state_next = RD_LO;
        end
      end
      RD_LO: begin
        stall = 1'b1;
        ld_lo = 1'b1;
        if (cap_dword) begin
          ram_addr   = hi_addr;
          state_next = RD_HI;
        end else begin
          state_next = DONE;
        end
      end
      RD_HI: begin
        stall      = 1'b1;
        ld_hi      = 1'b1;
        ram_addr   = hi_addr;
        state_next = DONE;
      end
      WR_HI: begin
        ram_addr   = hi_addr;
        ram_wdata  = cap_hi;
        ram_we     = 1'b1;
        ram_be     = 4'b1111;
        state_next = IDLE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset suppresses every side effect, including a pending high beat.
    if (reset) begin
      stall     = 1'b0;
      align_err = 1'b0;
      ram_we    = 1'b0;
      ram_be    = 4'b0000;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      readdata  <= 64'h0;
      cap_addr  <= 10'h0;
      cap_hi    <= 32'h0;
      cap_dword <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        cap_addr  <= dataadr[11:2];
        cap_hi    <= writedata[63:32];
        cap_dword <= req_dw;
      end
      if (ld_lo) begin
        readdata[31:0] <= ram_rdata;
        if (!cap_dword) readdata[63:32] <= 32'h0;
      end
      if (ld_hi) readdata[63:32] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-addressed reference memory, load-result scoreboard,
// directed corner cases followed by randomized traffic.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] dataadr;
  logic [63:0] writedata;
  logic [1:0]  memwrite;
  logic        memread;
  logic        dword;
  logic [63:0] readdata;
  logic        stall;
  logic        align_err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [2:0]  fsm_state;

  localparam logic [2:0] DONE_ST = 3'd4;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [1024];
  logic [7:0]  ref_mem [4096];
  logic [63:0] exp_q [$];
  logic [63:0] last_rd;

  dmem_ctrl dut (
    .clk(clk), .reset(reset), .dataadr(dataadr), .writedata(writedata),
    .memwrite(memwrite), .memread(memread), .dword(dword), .readdata(readdata),
    .stall(stall), .align_err(align_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_be(ram_be), .ram_rdata(ram_rdata), .fsm_state(fsm_state)
  );

  // ---------------- clock / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int w);
    int b;
    b = (w % 1024) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write_word(input int w, input logic [31:0] v);
    int b;
    b = (w % 1024) * 4;
    for (int i = 0; i < 4; i++) ref_mem[b+i] = v[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && fsm_state == DONE_ST) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL load_unexpected actual=%h expected=none", readdata);
      end else begin
        check("load_data", readdata, exp_q.pop_front());
      end
    end
    if (!ram_we) check("be_idle", {60'h0, ram_be}, 64'h0);
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [1:0] mw, input logic mr, input logic dw,
                       input logic [63:0] adr, input logic [63:0] wd);
    logic        st, ld, isdw, mis, done;
    logic [11:0] a;
    int          w, wh, exp_stall, exp_beats, stalls, aerr, nwe, cyc;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    @(posedge clk); #1;
    memwrite = mw; memread = mr; dword = dw; dataadr = adr; writedata = wd;
    a    = adr[11:0];
    w    = int'(a[11:2]);
    wh   = (w + 1) % 1024;
    st   = (mw != 2'b00);
    ld   = !st && mr;
    isdw = st ? (mw == 2'b11) : dw;
    if (isdw) mis = (st || ld) && (a[2:0] != 3'b000);
    else if (mw == 2'b10) mis = 1'b0;
    else mis = (st || ld) && (a[1:0] != 2'b00);
    exp_stall = 0; exp_beats = 0;
    if (!mis && st) begin exp_stall = isdw ? 1 : 0; exp_beats = isdw ? 2 : 1; end
    if (!mis && ld) exp_stall = dw ? 3 : 2;
    if (!mis && ld) begin
      last_rd = {dw ? ref_word(wh) : 32'h0, ref_word(w)};
      exp_q.push_back(last_rd);
    end
    stalls = 0; aerr = 0; nwe = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 12) begin
      @(negedge clk);
      if (align_err) aerr++;
      if (ram_we) begin
        if (nwe == 0) begin
          check("beat0_addr", {54'h0, ram_addr}, {54'h0, a[11:2]});
          exp_be = (mw == 2'b10) ? (4'b0001 << a[1:0]) : 4'b1111;
          exp_wd = (mw == 2'b10) ? {4{wd[7:0]}} : wd[31:0];
        end else begin
          check("beat1_addr", {54'h0, ram_addr}, wh[9:0]);
          exp_be = 4'b1111;
          exp_wd = wd[63:32];
        end
        check("store_be", {60'h0, ram_be}, {60'h0, exp_be});
        check("store_wdata", {32'h0, ram_wdata}, {32'h0, exp_wd});
        nwe++;
      end
      if (stall) stalls++;
      else done = 1'b1;
      cyc++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL op_timeout actual=stalled expected=release");
    end
    check("stall_cycles", stalls, exp_stall);
    check("align_err_cycles", aerr, mis ? 1 : 0);
    check("write_beats", nwe, exp_beats);
    if (!ld || mis) check("readdata_hold", readdata, last_rd);
    if (!mis && st) begin
      case (mw)
        2'b01: ref_write_word(w, wd[31:0]);
        2'b10: ref_mem[a] = wd[7:0];
        default: begin ref_write_word(w, wd[31:0]); ref_write_word(wh, wd[63:32]); end
      endcase
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    memwrite = 2'b00; memread = 1'b0; dword = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [63:0] adr, wd;
    logic [1:0]  mw;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_write_word(i, v);
    end
    last_rd = 64'h0;
    reset = 1'b1; memwrite = 2'b01; memread = 1'b1; dword = 1'b1;
    dataadr = 64'h3; writedata = 64'hdead_beef_cafe_f00d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {63'h0, stall}, 64'h0);
    check("rst_we", {63'h0, ram_we}, 64'h0);
    check("rst_align", {63'h0, align_err}, 64'h0);
    check("rst_readdata", readdata, 64'h0);
    @(posedge clk); #1;
    memwrite = 2'b00; memread = 1'b0; dword = 1'b0;
    reset = 1'b0;

    // dword store then dword load at 0x10
    do_op(2'b11, 1'b0, 1'b0, 64'h10, 64'h1122334455667788);
    do_op(2'b00, 1'b1, 1'b1, 64'h10, 64'h0);
    check("ram4", {32'h0, ram[4]}, 64'h55667788);
    check("ram5", {32'h0, ram[5]}, 64'h11223344);
    check("dword_rd", last_rd, 64'h1122334455667788);
    // byte store into lane 3, then word load of the same word
    do_op(2'b10, 1'b0, 1'b0, 64'h7, 64'hAB);
    do_op(2'b00, 1'b1, 1'b0, 64'h4, 64'h0);
    check("byte_lane", {32'h0, ram[1] & 32'hFF000000}, 64'hAB000000);
    // misaligned word load
    do_op(2'b00, 1'b1, 1'b0, 64'h6, 64'h0);
    // top-of-memory dword, misaligned dword load, aligned dword load
    do_op(2'b11, 1'b0, 1'b0, 64'hFF8, {$urandom, $urandom});
    do_op(2'b00, 1'b1, 1'b1, 64'hFFC, 64'h0);
    do_op(2'b00, 1'b1, 1'b1, 64'hFF8, 64'h0);
    // store wins over a simultaneous load
    do_op(2'b01, 1'b1, 1'b0, 64'h20, {$urandom, $urandom});
    go_idle();

    // reset while the high beat of a dword store is pending
    @(posedge clk); #1;
    memwrite = 2'b11; dataadr = 64'h40; writedata = 64'h0BAD_F00D_1234_5678;
    @(negedge clk);
    check("wrhi_pre_stall", {63'h0, stall}, 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("wrhi_rst_we", {63'h0, ram_we}, 64'h0);
    check("wrhi_rst_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    memwrite = 2'b00; reset = 1'b0;
    @(negedge clk);
    check("post_rst_we", {63'h0, ram_we}, 64'h0);
    check("post_rst_stall", {63'h0, stall}, 64'h0);
    check("post_rst_rd", readdata, 64'h0);
    ref_write_word(16, 32'h12345678);
    last_rd = 64'h0;
    do_op(2'b00, 1'b1, 1'b0, 64'h40, 64'h0);
    do_op(2'b00, 1'b1, 1'b0, 64'h44, 64'h0);

    // randomized traffic, biased toward aligned addresses
    for (int n = 0; n < 400; n++) begin
      adr = {$urandom, 20'h0, 12'($urandom_range(0, 4095))};
      case ($urandom_range(0, 3))
        0: adr[2:0] = 3'b000;
        1: adr[1:0] = 2'b00;
        default: ;
      endcase
      wd = {$urandom, $urandom};
      mw = 2'($urandom_range(0, 3));
      do_op(mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr, wd);
    end
    go_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    for (int i = 0; i < 1024; i++) check("ram_image", {32'h0, ram[i]}, {32'h0, ref_word(i)});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
